// File: rtl/cnn_pkg.sv
// Shared CNN datapath constants and helpers.
// Functions work on int so any CONV_BIT up to 32 can reuse them.
package cnn_pkg;

  localparam int CNN_CONV_BIT = 12;
  localparam int CNN_IMG_W    = 24;
  localparam int CNN_IMG_H    = 24;

  function automatic int smax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int relu(input int a);
    return (a > 0) ? a : 0;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Half-row buffer of horizontal maxima for 2x2 pooling.
// Sync write, async read: maps to distributed RAM.
module pool_line_buf
  import cnn_pkg::*;
#(
  parameter int CONV_BIT = CNN_CONV_BIT,
  parameter int DEPTH    = CNN_IMG_W / 2,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [AW-1:0]            addr,
  input  logic [2:0][CONV_BIT-1:0] wdata,
  output logic [2:0][CONV_BIT-1:0] rdata
);

  logic [2:0][CONV_BIT-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/pool2x2_relu_sequencer.sv
// Raster-order 2x2 max-pool + ReLU over a 3-channel conv stream.
// Even rows fill the line buffer, odd rows pool against it and emit.
module pool2x2_relu_sequencer
  import cnn_pkg::*;
#(
  parameter int CONV_BIT = CNN_CONV_BIT,
  parameter int IMG_W    = CNN_IMG_W,
  parameter int IMG_H    = CNN_IMG_H
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       soft_clr,
  input  logic                       valid_in,
  input  logic signed [CONV_BIT-1:0] conv_out_1,
  input  logic signed [CONV_BIT-1:0] conv_out_2,
  input  logic signed [CONV_BIT-1:0] conv_out_3,
  output logic        [CONV_BIT-1:0] max_value_1,
  output logic        [CONV_BIT-1:0] max_value_2,
  output logic        [CONV_BIT-1:0] max_value_3,
  output logic                       valid_out_relu,
  output logic                       frame_done
);

  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = $clog2(IMG_H);
  localparam int DEPTH = IMG_W / 2;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef logic signed [CONV_BIT-1:0] samp_t;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  samp_t         din  [3];
  samp_t         hreg [3];
  samp_t         hmax [3];
  samp_t         rlu  [3];
  samp_t         mv   [3];
  logic          accept;
  logic          emit;
  logic          lb_we;
  logic [AW-1:0] lb_addr;
  logic [2:0][CONV_BIT-1:0] lb_wdata;
  logic [2:0][CONV_BIT-1:0] lb_rdata;

  assign din[0] = conv_out_1;
  assign din[1] = conv_out_2;
  assign din[2] = conv_out_3;

  assign accept  = valid_in & ~soft_clr;
  assign emit    = row[0];
  assign lb_addr = AW'(col >> 1);
  assign lb_we   = rst_n & accept & col[0] & ~emit;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      hmax[i] = samp_t'(smax(int'(hreg[i]), int'(din[i])));
      lb_wdata[i] = hmax[i];
      rlu[i] = samp_t'(relu(smax(int'(hmax[i]),
                                 int'(samp_t'(lb_rdata[i])))));
    end
  end

  pool_line_buf #(
    .CONV_BIT (CONV_BIT),
    .DEPTH    (DEPTH)
  ) u_line_buf (
    .clk   (clk),
    .we    (lb_we),
    .addr  (lb_addr),
    .wdata (lb_wdata),
    .rdata (lb_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col            <= '0;
      row            <= '0;
      valid_out_relu <= 1'b0;
      frame_done     <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        hreg[i] <= '0;
        mv[i]   <= '0;
      end
    end else if (soft_clr) begin
      col            <= '0;
      row            <= '0;
      valid_out_relu <= 1'b0;
      frame_done     <= 1'b0;
      for (int i = 0; i < 3; i++) hreg[i] <= '0;
    end else begin
      valid_out_relu <= 1'b0;
      frame_done     <= 1'b0;
      if (valid_in) begin
        if (!col[0]) begin
          hreg <= din;
        end else if (emit) begin
          mv             <= rlu;
          valid_out_relu <= 1'b1;
          frame_done     <= (row == ROW_LAST) && (col == COL_LAST);
        end
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  assign max_value_1 = mv[0];
  assign max_value_2 = mv[1];
  assign max_value_3 = mv[2];

endmodule

// File: tb/tb_pool2x2_relu_sequencer.sv
// Bench: a 4x2 and a 24x24 instance share one stimulus stream,
// each with its own reference model and expected-pulse queue.
module tb_pool2x2_relu_sequencer;

  typedef struct {
    int stamp;
    int v0;
    int v1;
    int v2;
    bit fd;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic               soft_clr;
  logic               valid_in;
  logic signed [11:0] c1, c2, c3;

  logic [11:0] s_m1, s_m2, s_m3, d_m1, d_m2, d_m3;
  logic        s_v, s_fd, d_v, d_fd;

  pool2x2_relu_sequencer #(
    .CONV_BIT (12),
    .IMG_W    (4),
    .IMG_H    (2)
  ) u_small (
    .clk            (clk),
    .rst_n          (rst_n),
    .soft_clr       (soft_clr),
    .valid_in       (valid_in),
    .conv_out_1     (c1),
    .conv_out_2     (c2),
    .conv_out_3     (c3),
    .max_value_1    (s_m1),
    .max_value_2    (s_m2),
    .max_value_3    (s_m3),
    .valid_out_relu (s_v),
    .frame_done     (s_fd)
  );

  pool2x2_relu_sequencer u_dflt (
    .clk            (clk),
    .rst_n          (rst_n),
    .soft_clr       (soft_clr),
    .valid_in       (valid_in),
    .conv_out_1     (c1),
    .conv_out_2     (c2),
    .conv_out_3     (c3),
    .max_value_1    (d_m1),
    .max_value_2    (d_m2),
    .max_value_3    (d_m3),
    .valid_out_relu (d_v),
    .frame_done     (d_fd)
  );

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic rst_q = 1'b0;

  exp_t q [2][$];
  int   mcol [2];
  int   mrow [2];
  int   mh   [2][3];
  int   mlb  [2][12][3];
  int   lastv[2][3];
  int   pc   [2];
  int   fc   [2];

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst_n;
  end

  task automatic model(input int g, input int a, input int b, input int c);
    int w, h, hm, win;
    int s[3];
    int r[3];
    exp_t e;
    w = g ? 24 : 4;
    h = g ? 24 : 2;
    s[0] = a; s[1] = b; s[2] = c;
    if (mcol[g] % 2 == 0) begin
      for (int i = 0; i < 3; i++) mh[g][i] = s[i];
    end else begin
      for (int i = 0; i < 3; i++) begin
        hm = (s[i] > mh[g][i]) ? s[i] : mh[g][i];
        if (mrow[g] % 2 == 0) begin
          mlb[g][mcol[g] / 2][i] = hm;
          r[i] = 0;
        end else begin
          win  = (hm > mlb[g][mcol[g] / 2][i]) ? hm : mlb[g][mcol[g] / 2][i];
          r[i] = (win > 0) ? win : 0;
        end
      end
      if (mrow[g] % 2 == 1) begin
        e.stamp = cyc + 1;
        e.v0 = r[0];
        e.v1 = r[1];
        e.v2 = r[2];
        e.fd = (mrow[g] == h - 1) && (mcol[g] == w - 1);
        q[g].push_back(e);
      end
    end
    mcol[g]++;
    if (mcol[g] == w) begin
      mcol[g] = 0;
      mrow[g]++;
      if (mrow[g] == h) mrow[g] = 0;
    end
  endtask

  task automatic mon(input int g, input logic v, input logic fd,
                     input logic [11:0] a, input logic [11:0] b,
                     input logic [11:0] c);
    string p;
    exp_t  e;
    p = g ? "dflt" : "small";
    if (!rst_q) begin
      chk({p, "_rst_valid"}, int'(v), 0);
      chk({p, "_rst_done"}, int'(fd), 0);
      chk({p, "_rst_val1"}, int'(a), 0);
      chk({p, "_rst_val2"}, int'(b), 0);
      chk({p, "_rst_val3"}, int'(c), 0);
      for (int i = 0; i < 3; i++) lastv[g][i] = 0;
    end else if (v) begin
      pc[g]++;
      if (fd) fc[g]++;
      if (q[g].size() == 0) begin
        chk({p, "_spurious_pulse"}, q[g].size(), 1);
      end else begin
        e = q[g].pop_front();
        chk({p, "_latency"}, cyc, e.stamp);
        chk({p, "_val1"}, int'(a), e.v0);
        chk({p, "_val2"}, int'(b), e.v1);
        chk({p, "_val3"}, int'(c), e.v2);
        chk({p, "_frame_done"}, int'(fd), int'(e.fd));
        lastv[g][0] = e.v0;
        lastv[g][1] = e.v1;
        lastv[g][2] = e.v2;
      end
    end else begin
      chk({p, "_done_no_valid"}, int'(fd), 0);
      chk({p, "_hold1"}, int'(a), lastv[g][0]);
      chk({p, "_hold2"}, int'(b), lastv[g][1]);
      chk({p, "_hold3"}, int'(c), lastv[g][2]);
      if (q[g].size() > 0 && q[g][0].stamp <= cyc) begin
        chk({p, "_missed_pulse"}, int'(v), 1);
        void'(q[g].pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, s_v, s_fd, s_m1, s_m2, s_m3);
    mon(1, d_v, d_fd, d_m1, d_m2, d_m3);
  end

  task automatic step(input bit rn, input bit sc, input bit v,
                      input int a, input int b, input int c);
    @(posedge clk);
    #1;
    rst_n    = rn;
    soft_clr = sc;
    valid_in = v;
    c1 = 12'(a);
    c2 = 12'(b);
    c3 = 12'(c);
    for (int g = 0; g < 2; g++) begin
      if (!rn || sc) begin
        mcol[g] = 0;
        mrow[g] = 0;
      end else if (v) begin
        model(g, a, b, c);
      end
    end
  endtask

  task automatic beat(input int a, input int b, input int c);
    step(1'b1, 1'b0, 1'b1, a, b, c);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 0, 0, 0);
    for (int g = 0; g < 2; g++) begin
      pc[g] = 0;
      fc[g] = 0;
    end
  endtask

  function automatic int rnd12();
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  int r0[4] = '{1, 5, -3, 2};
  int r1[4] = '{4, -7, 9, 0};

  task automatic frame_a(input int max_gap);
    int x;
    for (int i = 0; i < 8; i++) begin
      x = (i < 4) ? r0[i] : r1[i - 4];
      beat(x, 100 * i - 300, -i);
      if (max_gap > 0) idle(int'($urandom_range(0, max_gap)));
    end
  endtask

  int n0[8] = '{-2048, 2047, -100, -200, -5, 0, -1, -300};

  initial begin
    rst_n    = 1'b0;
    soft_clr = 1'b0;
    valid_in = 1'b0;
    c1 = '0;
    c2 = '0;
    c3 = '0;

    step(1'b0, 1'b0, 1'b1, rnd12(), rnd12(), rnd12());
    step(1'b0, 1'b0, 1'b1, rnd12(), rnd12(), rnd12());
    do_reset();

    frame_a(0);
    idle(2);
    chk("basic_ch1_last", int'(s_m1), 9);
    chk("basic_pulses", pc[0], 2);
    chk("basic_frame_done", fc[0], 1);

    do_reset();
    for (int i = 0; i < 8; i++) beat(n0[i], -1, -2048);
    idle(2);
    chk("neg_pulses", pc[0], 2);
    chk("neg_ch2_zero", int'(s_m2), 0);
    chk("neg_ch3_zero", int'(s_m3), 0);

    do_reset();
    frame_a(3);
    idle(2);
    chk("gap_ch1_last", int'(s_m1), 9);
    chk("gap_pulses", pc[0], 2);
    chk("gap_frame_done", fc[0], 1);

    do_reset();
    for (int i = 0; i < 3; i++) beat(i + 10, i + 20, i + 30);
    step(1'b1, 1'b1, 1'b1, 77, 77, 77);
    frame_a(0);
    idle(2);
    chk("clr_pulses", pc[0], 2);
    chk("clr_frame_done", fc[0], 1);

    do_reset();
    for (int i = 0; i < 2 * 24 * 24; i++) beat(rnd12(), rnd12(), rnd12());
    idle(3);
    chk("rand_pulses", pc[1], 288);
    chk("rand_frame_done", fc[1], 2);
    chk("small_queue_empty", q[0].size(), 0);
    chk("dflt_queue_empty", q[1].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
